// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT,
        FAULT
    } fetch_state_e;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam int unsigned WORD_BYTES        = 4;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Program-memory read port and decode valid/ready handshake of the fetch sequencer.
interface instr_fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    import instr_fetch_sequencer_pkg::*;

    logic [DATA_WIDTH-1:0] mem_address_o;
    logic [DATA_WIDTH-1:0] mem_instruction_i;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic [DATA_WIDTH-1:0] instruction_o;
    logic [DATA_WIDTH-1:0] pc_o;

    modport master (
        output mem_address_o,
        input  mem_instruction_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instruction_o,
        output pc_o
    );

    modport slave (
        input  mem_address_o,
        output mem_instruction_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instruction_o,
        input  pc_o
    );

endinterface

// File: rtl/instr_fetch_sequencer_fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs; flush clears it in the same cycle.
module instr_fetch_sequencer_fetch_fifo
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch sequencer: FSM, fetch PC, range check and prefetch FIFO feeding decode.
// Optional FETCH_PERF_EN adds saturating push and full-stall counters.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  halt_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    instr_fetch_sequencer_if.master bus,
    output logic                  fault_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           fetch_count_o,
    output logic [31:0]           stall_count_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(MEMORY_DEPTH * WORD_BYTES);
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(WORD_BYTES);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] fetch_offset;
    logic [DATA_WIDTH-1:0] redirect_offset;
    logic                  fetch_in_range;
    logic                  redirect_legal;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;
    logic [2*DATA_WIDTH-1:0] fifo_head;

    // Offsets are modular, so PCs below TEXT_BASE wrap to huge offsets and fault.
    assign fetch_offset    = fetch_pc_q - TEXT_BASE;
    assign redirect_offset = redirect_pc_i - TEXT_BASE;
    assign fetch_in_range  = (fetch_offset < MEM_BYTES);
    assign redirect_legal  = (redirect_pc_i[1:0] == 2'b00) && (redirect_offset < MEM_BYTES);

    assign pop  = !fifo_empty && bus.instr_ready_i && !redirect_i;
    assign push = (state_q == RUN) && enable_i && !halt_i && !redirect_i
                  && fetch_in_range && (!fifo_full || pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            state_d    = redirect_legal ? RUN : FAULT;
            fault_d    = !redirect_legal;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable_i) state_d = RUN;
                end
                RUN: begin
                    if (halt_i || !enable_i) begin
                        state_d = HALT;
                    end else if (!fetch_in_range) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else if (push) begin
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end
                end
                HALT: begin
                    if (enable_i && !halt_i) state_d = RUN;
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= TEXT_BASE;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
        end
    end

    instr_fetch_sequencer_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * DATA_WIDTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_i),
        .wr_data ({bus.mem_instruction_i, fetch_pc_q}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    assign bus.mem_address_o = fetch_offset;
    assign bus.instr_valid_o = !fifo_empty;
    assign bus.instruction_o = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.pc_o          = fifo_head[DATA_WIDTH-1:0];
    assign fault_o           = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counters survive redirects; only reset clears them.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (push && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if ((state_q == RUN) && fifo_full && !pop && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count_o = fetch_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_instr_fetch_sequencer;

    localparam logic [31:0] TB_BASE   = 32'h0040_0000;
    localparam int          MEM_WORDS = 32;
    localparam int          MEM_BYTES = MEM_WORDS * 4;
    localparam int          DEPTH     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        halt;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] rom [MEM_WORDS];

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_running;
    bit          m_faulted;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;
`endif

    always #5 clk = ~clk;

    instr_fetch_sequencer_if #(.DATA_WIDTH(32)) fetch_bus ();

    assign fetch_bus.mem_instruction_i = (fetch_bus.mem_address_o < 32'(MEM_BYTES))
                                         ? rom[fetch_bus.mem_address_o[6:2]] : 32'hDEAD_BEEF;

    instr_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .bus           (fetch_bus),
        .fault_o       (fault)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count_o (fetch_count),
        .stall_count_o (stall_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        m_q.delete();
        m_pc      = TB_BASE;
        m_started = 1'b0;
        m_running = 1'b0;
        m_faulted = 1'b0;
`ifdef FETCH_PERF_EN
        m_fetches = '0;
        m_stalls  = '0;
`endif
    endfunction

    // One clock of the reference behaviour, evaluated on the inputs about to be clocked in.
    function automatic void modelStep(input bit en, input bit hl, input bit rd,
                                      input logic [31:0] rdpc, input bit rdy);
        logic [31:0] off;
        bit          pop;
        pop = (m_q.size() > 0) && rdy && !rd;
`ifdef FETCH_PERF_EN
        if (m_running && (m_q.size() == DEPTH) && !pop && (m_stalls != 32'hFFFF_FFFF)) m_stalls++;
`endif
        if (rd) begin
            m_q.delete();
            m_pc      = rdpc;
            off       = rdpc - TB_BASE;
            m_faulted = !((rdpc[1:0] == 2'b00) && (off < 32'(MEM_BYTES)));
            m_running = !m_faulted;
            m_started = 1'b1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_faulted) begin
                m_running = 1'b0;
            end else if (m_running) begin
                off = m_pc - TB_BASE;
                if (!en || hl) begin
                    m_running = 1'b0;
                end else if (off >= 32'(MEM_BYTES)) begin
                    m_faulted = 1'b1;
                    m_running = 1'b0;
                end else if (m_q.size() < DEPTH) begin
                    m_q.push_back({rom[off[6:2]], m_pc});
                    m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_EN
                    if (m_fetches != 32'hFFFF_FFFF) m_fetches++;
`endif
                end
            end else if (!m_started) begin
                if (en) begin
                    m_running = 1'b1;
                    m_started = 1'b1;
                end
            end else if (en && !hl) begin
                m_running = 1'b1;
            end
        end
    endfunction

    task automatic compareAll();
        checkOutput("valid", 64'(fetch_bus.instr_valid_o), 64'(m_q.size() > 0));
        checkOutput("fault", 64'(fault), 64'(m_faulted));
        checkOutput("mem_address", 64'(fetch_bus.mem_address_o), 64'(m_pc - TB_BASE));
        if (m_q.size() > 0) begin
            checkOutput("pc", 64'(fetch_bus.pc_o), 64'(m_q[0][31:0]));
            checkOutput("instruction", 64'(fetch_bus.instruction_o), 64'(m_q[0][63:32]));
        end
`ifdef FETCH_PERF_EN
        checkOutput("fetch_count", 64'(fetch_count), 64'(m_fetches));
        checkOutput("stall_count", 64'(stall_count), 64'(m_stalls));
`endif
    endtask

    // Called at a falling edge; drives inputs, advances the model, checks at the next falling edge.
    task automatic applyStimulus(input bit en, input bit hl, input bit rd,
                                 input logic [31:0] rdpc, input bit rdy);
        enable                  = en;
        halt                    = hl;
        redirect                = rd;
        redirect_pc             = rdpc;
        fetch_bus.instr_ready_i = rdy;
        modelStep(en, hl, rd, rdpc, rdy);
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    // Asserts reset between clock edges and checks the outputs clear without a clock.
    task automatic resetMidRun(input string tag);
        enable                  = 1'b0;
        halt                    = 1'b0;
        redirect                = 1'b0;
        redirect_pc             = '0;
        fetch_bus.instr_ready_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput({tag, "_rst_valid"}, 64'(fetch_bus.instr_valid_o), 64'd0);
        checkOutput({tag, "_rst_instr"}, 64'(fetch_bus.instruction_o), 64'd0);
        checkOutput({tag, "_rst_pc"}, 64'(fetch_bus.pc_o), 64'd0);
        checkOutput({tag, "_rst_fault"}, 64'(fault), 64'd0);
        checkOutput({tag, "_rst_addr"}, 64'(fetch_bus.mem_address_o), 64'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] pc_pick;
        bit          en, hl, rd, rdy;

        reset                   = 1'b1;
        enable                  = 1'b0;
        halt                    = 1'b0;
        redirect                = 1'b0;
        redirect_pc             = '0;
        fetch_bus.instr_ready_i = 1'b0;
        for (int k = 0; k < MEM_WORDS; k++) rom[k] = 32'(k + 1);
        @(negedge clk);
        resetMidRun("init");

        // Streaming fetch with decode always ready.
        applyStimulus(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 1);
            checkOutput("t1_pc", 64'(fetch_bus.pc_o), 64'(TB_BASE + 32'(4 * i)));
            checkOutput("t1_instr", 64'(fetch_bus.instruction_o), 64'(i + 1));
            checkOutput("t1_addr", 64'(fetch_bus.mem_address_o), 64'(4 * (i + 1)));
        end

        // Decode stalls: FIFO fills to four and the fetch address freezes.
        resetMidRun("t2");
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t2_addr_frozen", 64'(fetch_bus.mem_address_o), 64'h10);
        checkOutput("t2_head_pc", 64'(fetch_bus.pc_o), 64'(TB_BASE));
        checkOutput("t2_head_instr", 64'(fetch_bus.instruction_o), 64'd1);
`ifdef FETCH_PERF_EN
        checkOutput("t2_fetch_count", 64'(fetch_count), 64'd4);
        checkOutput("t2_stall_count", 64'(stall_count), 64'd6);
`endif
        for (int j = 2; j <= 5; j++) begin
            applyStimulus(1, 0, 0, 0, 1);
            checkOutput("t2_drain_instr", 64'(fetch_bus.instruction_o), 64'(j));
            checkOutput("t2_drain_valid", 64'(fetch_bus.instr_valid_o), 64'd1);
        end

        // Redirect while three entries are queued.
        resetMidRun("t3");
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h0040_0040, 1);
        checkOutput("t3_flush_valid", 64'(fetch_bus.instr_valid_o), 64'd0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t3_new_pc", 64'(fetch_bus.pc_o), 64'h0040_0040);
        checkOutput("t3_new_instr", 64'(fetch_bus.instruction_o), 64'd17);

        // Run off the end of program memory, then recover with a legal redirect.
        applyStimulus(1, 0, 1, 32'h0040_0070, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t4_last_pc", 64'(fetch_bus.pc_o), 64'h0040_007C);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t4_fault", 64'(fault), 64'd1);
        checkOutput("t4_no_push", 64'(fetch_bus.instr_valid_o), 64'd0);
        applyStimulus(1, 0, 1, TB_BASE, 1);
        checkOutput("t4_fault_clear", 64'(fault), 64'd0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t4_resume_pc", 64'(fetch_bus.pc_o), 64'(TB_BASE));

        // Misaligned redirect faults; reset clears everything asynchronously.
        applyStimulus(1, 0, 1, 32'h0040_0002, 1);
        checkOutput("t5_fault", 64'(fault), 64'd1);
        checkOutput("t5_valid", 64'(fetch_bus.instr_valid_o), 64'd0);
        applyStimulus(1, 0, 0, 0, 1);
        resetMidRun("t5");

        // Randomized traffic against the reference model.
        for (int k = 0; k < MEM_WORDS; k++) rom[k] = $urandom;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) resetMidRun("rand");
            en  = ($urandom_range(0, 9) != 0);
            hl  = ($urandom_range(0, 9) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0, 1:    pc_pick = TB_BASE + 32'(4 * $urandom_range(0, MEM_WORDS - 1));
                2:       pc_pick = TB_BASE + 32'($urandom_range(0, MEM_BYTES - 1));
                default: pc_pick = TB_BASE + 32'(4 * $urandom_range(24, 40)) - 32'd8;
            endcase
            applyStimulus(en, hl, rd, pc_pick, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
